// File: rtl/seq_frame_tx.sv
// Serial frame transmitter: sync word, MSB-first payload, even parity, then idle gap.
// Payload is taken over a valid/ready handshake; one bit leaves per clock.
module seq_frame_tx #(
    parameter int unsigned       SYNC_W = 4,
    parameter logic [SYNC_W-1:0] SYNC   = 4'b1011,
    parameter int unsigned       DATA_W = 8,
    parameter int unsigned       GAP    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_valid,
    output logic              data_ready,
    output logic              out_bit,
    output logic              out_valid,
    output logic              frame_start,
    output logic              tx_done,
    output logic              busy
);

    localparam int unsigned FRAME_W = SYNC_W + DATA_W;
    localparam int unsigned LEN_SD  = (SYNC_W > DATA_W) ? SYNC_W : DATA_W;
    localparam int unsigned MAX_LEN = (LEN_SD > GAP) ? LEN_SD : GAP;
    localparam int unsigned CNT_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC,
        S_DATA,
        S_PARITY,
        S_GAP
    } state_t;

    state_t             state_q, state_n;
    logic [CNT_W-1:0]   cnt_q, cnt_n;
    logic [FRAME_W-1:0] frame_q, frame_n;
    logic               par_q, par_n;
    logic               out_bit_n, out_valid_n, frame_start_n, tx_done_n;

    // Sync word and payload share one shift register; the bit on out_bit has already left it.
    always_comb begin
        state_n       = state_q;
        cnt_n         = cnt_q;
        frame_n       = frame_q;
        par_n         = par_q;
        out_bit_n     = 1'b0;
        out_valid_n   = 1'b0;
        frame_start_n = 1'b0;
        tx_done_n     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (data_valid && data_ready) begin
                    state_n       = S_SYNC;
                    cnt_n         = CNT_W'(SYNC_W - 1);
                    frame_n       = {SYNC, data_in} << 1;
                    par_n         = ^data_in;
                    out_bit_n     = SYNC[SYNC_W-1];
                    out_valid_n   = 1'b1;
                    frame_start_n = 1'b1;
                end
            end
            S_SYNC: begin
                out_bit_n   = frame_q[FRAME_W-1];
                out_valid_n = 1'b1;
                frame_n     = frame_q << 1;
                if (cnt_q == '0) begin
                    state_n = S_DATA;
                    cnt_n   = CNT_W'(DATA_W - 1);
                end else begin
                    cnt_n = cnt_q - CNT_W'(1);
                end
            end
            S_DATA: begin
                out_valid_n = 1'b1;
                if (cnt_q == '0) begin
                    state_n   = S_PARITY;
                    cnt_n     = '0;
                    out_bit_n = par_q;
                    tx_done_n = 1'b1;
                end else begin
                    out_bit_n = frame_q[FRAME_W-1];
                    frame_n   = frame_q << 1;
                    cnt_n     = cnt_q - CNT_W'(1);
                end
            end
            S_PARITY: begin
                if (GAP > 0) begin
                    state_n = S_GAP;
                    cnt_n   = CNT_W'(GAP - 1);
                end else begin
                    state_n = S_IDLE;
                    cnt_n   = '0;
                end
            end
            S_GAP: begin
                if (cnt_q == '0) begin
                    state_n = S_IDLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_n = S_IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    // Reset aborts any frame in flight and drops the captured payload.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            frame_q     <= '0;
            par_q       <= 1'b0;
            out_bit     <= 1'b0;
            out_valid   <= 1'b0;
            frame_start <= 1'b0;
            tx_done     <= 1'b0;
            busy        <= 1'b0;
            data_ready  <= 1'b0;
        end else begin
            state_q     <= state_n;
            cnt_q       <= cnt_n;
            frame_q     <= frame_n;
            par_q       <= par_n;
            out_bit     <= out_bit_n;
            out_valid   <= out_valid_n;
            frame_start <= frame_start_n;
            tx_done     <= tx_done_n;
            busy        <= (state_n != S_IDLE);
            data_ready  <= (state_n == S_IDLE);
        end
    end

endmodule
